switch_box_param: RTL and testbench
===================================

Name: switch_box_param

Overview:
Parametrised, configurable switch box: the next generation of the fixed 4-side/4-track switch boxes used in the PE tiles. It generalises side count, track count and track width. Each output track has its own source select and an optional pipeline register. Configuration is held internally and written over the standard config bus, with its own address match. Adds config readback and a per-output registered/combinational mode, which the fixed-corner switch boxes lack.

Parameters:
N_SIDES, 4, number of sides (2..8)
N_TRACKS, 4, tracks per side (1..32)
TRACK_WIDTH, 1, bits per track
CONFIG_ID, 1, block id matched against config_addr[15:8]
Derived localparams (not overridable):
- SEL_W = clog2(N_SIDES)
- FW = SEL_W+1
- FPW = 32/FW
- N_OUT = N_SIDES*N_TRACKS
- N_WORDS = ceil(N_OUT/FPW)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
config_write  in  1  config write strobe
config_read  in  1  config read strobe
config_addr  in  32  [31:16] tile id, [15:8] block id, [7:0] word index
config_data  in  32  write data
tile_id  in  16  this tile's id
in_wires  in  N_SIDES*N_TRACKS*TRACK_WIDTH  input tracks; track (s,t) at offset (s*N_TRACKS+t)*TRACK_WIDTH
out_wires  out  N_SIDES*N_TRACKS*TRACK_WIDTH  output tracks; same packing as in_wires
read_data  out  32  readback word
read_valid  out  1  readback valid pulse

Behaviour:
- Single clock clk. reset is asynchronous, active-high, and clears all state.
- Output (s,t) has field index f = s*N_TRACKS+t. Its field sits in word f/FPW, bits [(f%FPW)*FW +: FW].
- Field layout: bits [SEL_W-1:0] = sel, bit SEL_W = reg_en. Word bits above FPW*FW are unused: written value ignored, read as 0.
- sel = 0: output drives zero.
- sel = k with 1 <= k <= N_SIDES-1: output takes in_wires track t of side (s+k) mod N_SIDES.
- sel >= N_SIDES (only possible for non-power-of-2 N_SIDES): output drives zero.
- Match = (config_addr[31:16] == tile_id) && (config_addr[15:8] == CONFIG_ID) && (config_addr[7:0] < N_WORDS).
- Write: on a clk edge with config_write && match, the whole word is replaced. The new routing is in effect from that edge.
- Read: on a clk edge with config_read, read_valid is 1 for the next cycle. read_data is the addressed word's value before any same-edge write, so write+read to the same word returns the old value.
- Read with tile/block id mismatch: read_valid stays 0.
- Read with ids matching but index >= N_WORDS: read_valid = 1, read_data = 0.
- read_data holds its value when read_valid = 0.
- Writes with tile/block id mismatch or index out of range are ignored; no state changes.
- reg_en = 0: output is combinational from in_wires and the config, zero latency.
- reg_en = 1: output comes from a per-output pipeline register. It lags the selected input by one clk.
- Pipeline registers capture the mux result every cycle, whatever reg_en is. Toggling reg_en therefore switches paths with no stale-data bubble beyond one cycle.
- Reset values:
  - All config words 0, so every sel = 0 and every reg_en = 0.
  - All pipeline registers 0.
  - out_wires all 0, read_data 0, read_valid 0.
- Reset asserted mid-operation: outputs go to 0 immediately (asynchronous). Any pending read_valid is dropped.
- Strobes arriving while reset is asserted are ignored.
- Simultaneous config_write and config_read to different words: both are performed.

Decomposition:
- Shared package sb_cfg_pkg holds:
  - Address field positions (tile id [31:16], block id [15:8], index [7:0]).
  - The clog2-based field-width helper functions.
  - The SEL_ZERO = 0 encoding.
- One sub-module, sb_track_mux: one output track's (N_SIDES-1)-way select, zero default, and optional pipeline register. It is instantiated N_OUT times in a generate loop.
- Config storage, address match and readback stay in the top level.

Test Plan:
All scenarios use default parameters (SEL_W = 2, FW = 3, FPW = 10, N_WORDS = 2), tile_id = 0x0001, and in_wires driven with random patterns unless stated.
- Reset: assert reset with random in_wires, then read word 0 and word 1 -> out_wires = 0; read_data = 0 with read_valid = 1 on the cycle after each read.
- Combinational route: write addr 0x00010100, data 0x00000001 (f0 sel = 1) -> out side0 track0 equals in side1 track0 in the same cycle after the write edge; all other outputs remain 0.
- Registered route:
  - Write data 0x00000005 (sel = 1, reg_en = 1), then toggle in side1 track0 -> out side0 track0 follows one clk later.
  - Rewrite data 0x00000001 -> out side0 track0 becomes combinational again.
- Address filtering:
  - Write with config_addr 0x00020100 or 0x00010200 -> no change; a read with config_addr 0x00020100 or 0x00010200 -> read_valid stays 0.
  - Index 0x02 (out of range): write ignored; read gives read_valid = 1, read_data = 0.
- Readback ordering: write word 1 with 0x3FFFFFFF while reading word 1 at the same edge -> returns the old value, with bits 31:30 = 0 since they are unused. The next read returns 0x3FFFFFFF. Bits 17:0 of word 1 set f10..f15 to sel = 3, reg_en = 1 -> out side3 track2 equals in side2 track2 delayed one clk.
- Async reset mid-traffic: assert reset between clk edges while reg_en routes are active -> out_wires = 0 immediately. After release, everything stays 0 until reconfigured.

Source files
------------

// File: rtl/sb_cfg_pkg.sv
// Shared definitions for the parametrised switch box: config address
// field positions, field-width helpers and the select encodings.
package sb_cfg_pkg;

  // Config address layout: [31:16] tile id, [15:8] block id, [7:0] word index
  localparam int ADDR_TILE_LSB  = 16;
  localparam int ADDR_TILE_W    = 16;
  localparam int ADDR_BLOCK_LSB = 8;
  localparam int ADDR_BLOCK_W   = 8;
  localparam int ADDR_INDEX_LSB = 0;
  localparam int ADDR_INDEX_W   = 8;

  // sel value that forces an output to zero
  localparam int SEL_ZERO = 0;

  // Width of a source select for a given side count
  function automatic int sel_width(input int n_sides);
    return (n_sides <= 2) ? 1 : $clog2(n_sides);
  endfunction

  // One config field: sel plus the reg_en bit
  function automatic int field_width(input int n_sides);
    return sel_width(n_sides) + 1;
  endfunction

  // Whole fields packed into one 32-bit config word
  function automatic int fields_per_word(input int n_sides);
    return 32 / field_width(n_sides);
  endfunction

  // Config words needed to hold one field per output track
  function automatic int num_words(input int n_sides, input int n_tracks);
    return (n_sides * n_tracks + fields_per_word(n_sides) - 1) /
           fields_per_word(n_sides);
  endfunction

endpackage

// File: rtl/sb_track_mux.sv
// One output track: selects among the tracks of the other sides (already
// rotated so entry k-1 is the side k steps away), with an optional
// pipeline register in the output path.
module sb_track_mux
  import sb_cfg_pkg::*;
#(
  parameter int N_SIDES     = 4,
  parameter int TRACK_WIDTH = 1,
  parameter int SEL_W       = sel_width(N_SIDES)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [(N_SIDES-1)*TRACK_WIDTH-1:0] track_in,
  input  logic [SEL_W-1:0]                   sel,
  input  logic                               reg_en,
  output logic [TRACK_WIDTH-1:0]             track_out
);

  logic [TRACK_WIDTH-1:0] mux_val;
  logic [TRACK_WIDTH-1:0] pipe_q;

  // Source select; SEL_ZERO and any sel >= N_SIDES leave the output at zero
  always_comb begin
    // NOTE: the default before the loop keeps every path assigned, so no latch is inferred.
    mux_val = '0;
    for (int k = 1; k < N_SIDES; k++) begin
      if (sel == SEL_W'(k)) mux_val = track_in[(k-1)*TRACK_WIDTH +: TRACK_WIDTH];
    end
  end

  // Pipeline register captures the mux every cycle, whatever reg_en is
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: non-blocking so every flop samples pre-edge values regardless of block order.
    if (reset) pipe_q <= '0;
    else       pipe_q <= mux_val;
  end

  // Registered or combinational path per reg_en
  always_comb begin
    track_out = reg_en ? pipe_q : mux_val;
  end

endmodule

// File: rtl/switch_box_param.sv
// Parametrised switch box: config word storage, address match and
// readback, plus one sb_track_mux per output track.
module switch_box_param
  import sb_cfg_pkg::*;
#(
  parameter int N_SIDES     = 4,
  parameter int N_TRACKS    = 4,
  parameter int TRACK_WIDTH = 1,
  parameter int CONFIG_ID   = 1
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   config_write,
  input  logic                                   config_read,
  input  logic [31:0]                            config_addr,
  input  logic [31:0]                            config_data,
  input  logic [15:0]                            tile_id,
  input  logic [N_SIDES*N_TRACKS*TRACK_WIDTH-1:0] in_wires,
  output logic [N_SIDES*N_TRACKS*TRACK_WIDTH-1:0] out_wires,
  output logic [31:0]                            read_data,
  output logic                                   read_valid
);

  localparam int SEL_W     = sel_width(N_SIDES);
  localparam int FW        = field_width(N_SIDES);
  localparam int FPW       = fields_per_word(N_SIDES);
  localparam int N_OUT     = N_SIDES * N_TRACKS;
  localparam int N_WORDS   = num_words(N_SIDES, N_TRACKS);
  localparam int WORD_USED = FPW * FW;

  // Bits above the last whole field are never stored
  localparam logic [31:0] USED_MASK =
    (WORD_USED >= 32) ? 32'hFFFF_FFFF : ((32'd1 << WORD_USED) - 32'd1);
  localparam logic [8:0]  N_WORDS_LIM = 9'(N_WORDS);

  logic [N_WORDS-1:0][31:0]  cfg_q;
  logic [ADDR_TILE_W-1:0]    addr_tile;
  logic [ADDR_BLOCK_W-1:0]   addr_block;
  logic [ADDR_INDEX_W-1:0]   addr_index;
  logic                      ids_match;
  logic                      index_ok;
  logic [31:0]               rd_word;

  assign addr_tile  = config_addr[ADDR_TILE_LSB  +: ADDR_TILE_W];
  assign addr_block = config_addr[ADDR_BLOCK_LSB +: ADDR_BLOCK_W];
  assign addr_index = config_addr[ADDR_INDEX_LSB +: ADDR_INDEX_W];
  assign ids_match  = (addr_tile == tile_id) && (addr_block == ADDR_BLOCK_W'(CONFIG_ID));
  assign index_ok   = ({1'b0, addr_index} < N_WORDS_LIM);

  // Addressed word as stored before this edge; out-of-range index reads 0
  always_comb begin
    rd_word = '0;
    for (int w = 0; w < N_WORDS; w++) begin
      if ({1'b0, addr_index} == 9'(w)) rd_word = cfg_q[w];
    end
  end

  // Config word writes; unused top bits are masked off on the way in
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: config storage is reset because all routes must read as sel=0 straight out of reset.
    if (reset) begin
      cfg_q <= '0;
    end else if (config_write && ids_match && index_ok) begin
      for (int w = 0; w < N_WORDS; w++) begin
        if ({1'b0, addr_index} == 9'(w)) cfg_q[w] <= config_data & USED_MASK;
      end
    end
  end

  // Readback: one-cycle valid pulse, data held between reads
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      read_valid <= 1'b0;
      read_data  <= '0;
    end else begin
      read_valid <= config_read && ids_match;
      if (config_read && ids_match) read_data <= rd_word;
    end
  end

  // One mux per output; field f sits at word f/FPW, bits (f%FPW)*FW
  for (genvar s = 0; s < N_SIDES; s++) begin : g_side
    for (genvar t = 0; t < N_TRACKS; t++) begin : g_track
      localparam int F = s * N_TRACKS + t;
      logic [(N_SIDES-1)*TRACK_WIDTH-1:0] srcs;

      for (genvar k = 1; k < N_SIDES; k++) begin : g_src
        assign srcs[(k-1)*TRACK_WIDTH +: TRACK_WIDTH] =
          in_wires[(((s + k) % N_SIDES) * N_TRACKS + t) * TRACK_WIDTH +: TRACK_WIDTH];
      end

      sb_track_mux #(
        .N_SIDES     (N_SIDES),
        .TRACK_WIDTH (TRACK_WIDTH),
        .SEL_W       (SEL_W)
      ) u_mux (
        .clk       (clk),
        .reset     (reset),
        .track_in  (srcs),
        .sel       (cfg_q[F / FPW][(F % FPW) * FW +: SEL_W]),
        .reg_en    (cfg_q[F / FPW][(F % FPW) * FW + SEL_W]),
        .track_out (out_wires[F * TRACK_WIDTH +: TRACK_WIDTH])
      );
    end
  end

endmodule

// File: tb/tb_switch_box_param.sv
// Directed bench for switch_box_param at default parameters (4 sides,
// 4 tracks, 1-bit tracks, 2 config words), tile id 0x0001.
module tb_switch_box_param;

  logic        clk = 1'b0;
  logic        reset;
  logic        config_write;
  logic        config_read;
  logic [31:0] config_addr;
  logic [31:0] config_data;
  logic [15:0] tile_id;
  logic [15:0] in_wires;
  logic [15:0] out_wires;
  logic [31:0] read_data;
  logic        read_valid;

  int errors = 0;
  int checks = 0;

  localparam logic [31:0] A_W0     = 32'h0001_0100;
  localparam logic [31:0] A_W1     = 32'h0001_0101;
  localparam logic [31:0] A_W2     = 32'h0001_0102;
  localparam logic [31:0] A_BADTL  = 32'h0002_0100;
  localparam logic [31:0] A_BADBLK = 32'h0001_0200;

  switch_box_param dut (
    .clk          (clk),
    .reset        (reset),
    .config_write (config_write),
    .config_read  (config_read),
    .config_addr  (config_addr),
    .config_data  (config_data),
    .tile_id      (tile_id),
    .in_wires     (in_wires),
    .out_wires    (out_wires),
    .read_data    (read_data),
    .read_valid   (read_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Drive one strobe cycle between edges; returns 1 ns after the sampling edge
  task automatic cfg_cycle(input logic wr, input logic rd, input logic [31:0] addr,
                           input logic [31:0] data);
    @(negedge clk);
    config_write = wr;
    config_read  = rd;
    config_addr  = addr;
    config_data  = data;
    @(posedge clk);
    #1;
    config_write = 1'b0;
    config_read  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset        = 1'b1;
    config_write = 1'b0;
    config_read  = 1'b0;
    config_addr  = '0;
    config_data  = '0;
    tile_id      = 16'h0001;
    in_wires     = 16'($urandom);

    // Reset state
    #1;
    check("reset_out", 32'(out_wires), 32'h0);
    check("reset_rv", 32'(read_valid), 32'h0);
    check("reset_rd", read_data, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    in_wires = 16'($urandom);
    #1;
    check("post_reset_out", 32'(out_wires), 32'h0);

    cfg_cycle(1'b0, 1'b1, A_W0, '0);
    check("rd_w0_rv", 32'(read_valid), 32'h1);
    check("rd_w0_data", read_data, 32'h0);
    @(posedge clk); #1;
    check("rv_pulse", 32'(read_valid), 32'h0);
    cfg_cycle(1'b0, 1'b1, A_W1, '0);
    check("rd_w1_rv", 32'(read_valid), 32'h1);
    check("rd_w1_data", read_data, 32'h0);

    // Combinational route: out(0,0) <- in(1,0) = bit 4
    in_wires = 16'h0010;
    cfg_cycle(1'b1, 1'b0, A_W0, 32'h0000_0001);
    check("comb_hi", 32'(out_wires), 32'h0001);
    in_wires = 16'hFFEF;
    #1;
    check("comb_lo", 32'(out_wires), 32'h0000);

    // Registered route: same source, one clk lag
    in_wires = 16'h0000;
    cfg_cycle(1'b1, 1'b0, A_W0, 32'h0000_0005);
    @(negedge clk);
    in_wires = 16'h0010;
    #1;
    check("reg_lag", 32'(out_wires), 32'h0000);
    @(posedge clk); #1;
    check("reg_rise", 32'(out_wires), 32'h0001);
    @(negedge clk);
    in_wires = 16'h0000;
    #1;
    check("reg_hold", 32'(out_wires), 32'h0001);
    @(posedge clk); #1;
    check("reg_fall", 32'(out_wires), 32'h0000);

    // Back to combinational
    cfg_cycle(1'b1, 1'b0, A_W0, 32'h0000_0001);
    in_wires = 16'h0010;
    #1;
    check("comb_again", 32'(out_wires), 32'h0001);

    // Address filtering: mismatched writes must not clear word 0
    cfg_cycle(1'b1, 1'b0, A_BADTL, 32'h0);
    check("bad_tile_wr", 32'(out_wires), 32'h0001);
    cfg_cycle(1'b1, 1'b0, A_BADBLK, 32'h0);
    check("bad_blk_wr", 32'(out_wires), 32'h0001);
    cfg_cycle(1'b1, 1'b0, A_W2, 32'hFFFF_FFFF);
    check("oor_wr_out", 32'(out_wires), 32'h0001);
    cfg_cycle(1'b0, 1'b1, A_W0, '0);
    check("rd_w0_new", read_data, 32'h0000_0001);
    cfg_cycle(1'b0, 1'b1, A_BADTL, '0);
    check("bad_tile_rv", 32'(read_valid), 32'h0);
    check("rd_hold", read_data, 32'h0000_0001);
    cfg_cycle(1'b0, 1'b1, A_BADBLK, '0);
    check("bad_blk_rv", 32'(read_valid), 32'h0);
    cfg_cycle(1'b0, 1'b1, A_W2, '0);
    check("oor_rd_rv", 32'(read_valid), 32'h1);
    check("oor_rd_data", read_data, 32'h0);
    cfg_cycle(1'b0, 1'b1, A_W1, '0);
    check("w1_untouched", read_data, 32'h0);

    // Same-edge write+read of word 1 returns the old value
    cfg_cycle(1'b1, 1'b1, A_W1, 32'hFFFF_FFFF);
    check("wr_rd_rv", 32'(read_valid), 32'h1);
    check("wr_rd_old", read_data, 32'h0);
    cfg_cycle(1'b0, 1'b1, A_W1, '0);
    check("rd_w1_masked", read_data, 32'h3FFF_FFFF);

    // f10..f15 sel=3 reg_en=1: out bits 10..15 <- in bits 6..11, registered
    @(negedge clk);
    in_wires = 16'h0000;
    @(posedge clk); #1;
    check("w1_idle", 32'(out_wires), 32'h0000);
    @(negedge clk);
    in_wires = 16'h0400;
    #1;
    check("s3t2_lag", 32'(out_wires), 32'h0000);
    @(posedge clk); #1;
    check("s3t2_rise", 32'(out_wires), 32'h4000);
    @(negedge clk);
    in_wires = 16'h0AD0;
    #1;
    check("mix_pre", 32'(out_wires), 32'h4001);
    @(posedge clk); #1;
    check("mix_post", 32'(out_wires), 32'hAC01);

    // Async reset between edges drops outputs and a pending read_valid
    cfg_cycle(1'b0, 1'b1, A_W0, '0);
    check("pre_rst_rv", 32'(read_valid), 32'h1);
    #1;
    reset = 1'b1;
    #1;
    check("arst_out", 32'(out_wires), 32'h0);
    check("arst_rv", 32'(read_valid), 32'h0);
    check("arst_rd", read_data, 32'h0);
    @(negedge clk);
    config_write = 1'b1;
    config_read  = 1'b1;
    config_addr  = A_W0;
    config_data  = 32'h0000_0005;
    @(posedge clk); #1;
    check("rst_strobe_rv", 32'(read_valid), 32'h0);
    @(negedge clk);
    config_write = 1'b0;
    config_read  = 1'b0;
    reset        = 1'b0;
    in_wires     = 16'hFFFF;
    #1;
    check("post_arst_comb", 32'(out_wires), 32'h0);
    @(posedge clk); #1;
    check("post_arst_reg", 32'(out_wires), 32'h0);
    cfg_cycle(1'b0, 1'b1, A_W0, '0);
    check("post_arst_w0", read_data, 32'h0);
    cfg_cycle(1'b0, 1'b1, A_W1, '0);
    check("post_arst_w1", read_data, 32'h0);
    check("post_arst_w1rv", 32'(read_valid), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
